// File: rtl/multicycle_sequencer.sv
// Multi-cycle controller: owns PC/IR, sequences FETCH/DECODE/EXEC/MEM/WB,
// drives ALU/regfile/dmem strobes and traps hung memory accesses in FAULT.
module multicycle_sequencer #(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            halt_req,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_rdata,
  input  logic            imem_ack,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  input  logic            alu_zero,
  output logic [7:0]      ir,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      alu_control,
  output logic            alu_src,
  output logic            reg_we,
  output logic            mem_to_reg,
  output logic            link_we,
  output logic [2:0]      state,
  output logic            busy,
  output logic            fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  state_t          st, st_d;
  logic [PC_W-1:0] pc_d;
  logic [7:0]      ir_d;
  logic [3:0]      wdog, wdog_d;

  logic [3:0]      op;
  logic            is_lw, is_sw, is_jal;
  logic [PC_W-1:0] br_off, br_tgt, jmp_tgt;
  logic            wd_exp;
  state_t          bnd;

  assign op     = ir[7:4];
  assign is_lw  = (op == 4'b1010);
  assign is_sw  = (op == 4'b1011);
  assign is_jal = (op == 4'b1001);

  // branch offset is 4-bit signed, relative to the already-incremented pc
  assign br_off = PC_W'($signed(ir[3:0]));
  assign br_tgt = pc + br_off;

  // absolute jumps replace only the low nibble of pc
  if (PC_W > 4) begin : g_jt
    assign jmp_tgt = {pc[PC_W-1:4], ir[3:0]};
  end else begin : g_jt4
    assign jmp_tgt = ir[3:0];
  end

  // this cycle would be the last allowed wait cycle without an ack
  assign wd_exp = (({1'b0, wdog} + 5'd1) == 5'(TIMEOUT));

  // every entry into FETCH is an instruction boundary where halt is honoured
  assign bnd = halt_req ? S_HALT : S_FETCH;

  // next-state, pc and ir update
  always_comb begin
    st_d = st;
    pc_d = pc;
    ir_d = ir;
    case (st)
      S_IDLE:   if (start) st_d = bnd;
      S_FETCH: begin
        if (imem_ack) begin
          ir_d = imem_rdata;
          pc_d = pc + PC_W'(1);
          st_d = S_DECODE;
        end else if (wd_exp) begin
          st_d = S_FAULT;
        end
      end
      S_DECODE: st_d = S_EXEC;
      S_EXEC: begin
        case (op)
          4'b1010, 4'b1011: st_d = S_MEM;
          4'b1000: begin
            pc_d = jmp_tgt;
            st_d = bnd;
          end
          4'b1100: begin
            if (alu_zero) pc_d = br_tgt;
            st_d = bnd;
          end
          4'b1101: begin
            if (!alu_zero) pc_d = br_tgt;
            st_d = bnd;
          end
          default:          st_d = S_WB;  // ALU/imm and jal
        endcase
      end
      S_MEM: begin
        if (dmem_ack)    st_d = is_sw ? bnd : S_WB;
        else if (wd_exp) st_d = S_FAULT;
      end
      S_WB: begin
        if (is_jal) pc_d = jmp_tgt;
        st_d = bnd;
      end
      S_HALT:   if (!halt_req && start) st_d = S_FETCH;
      default:  st_d = S_FAULT;  // FAULT is sticky until reset
    endcase
    // watchdog runs only while parked in a wait state; any transition clears it
    wdog_d = ((st_d == st) && ((st == S_FETCH) || (st == S_MEM))) ? wdog + 4'd1 : 4'd0;
  end

  // state, pc, ir and watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= S_IDLE;
      pc   <= '0;
      ir   <= '0;
      wdog <= '0;
    end else begin
      st   <= st_d;
      pc   <= pc_d;
      ir   <= ir_d;
      wdog <= wdog_d;
    end
  end

  assign state       = st;
  assign imem_req    = (st == S_FETCH);
  assign imem_addr   = pc;
  assign dmem_req    = (st == S_MEM);
  assign dmem_we     = (st == S_MEM) && is_sw;
  assign alu_control = ((st == S_EXEC) || (st == S_MEM) || (st == S_WB)) ? ir[6:4] : 3'd0;
  assign alu_src     = !is_sw;
  assign reg_we      = (st == S_WB) && !is_jal;
  assign mem_to_reg  = (st == S_WB) && is_lw;
  assign link_we     = (st == S_WB) && is_jal;
  assign busy        = (st >= S_FETCH) && (st <= S_WB);
  assign fault       = (st == S_FAULT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: the stimulus queues the expected state trace, a monitor
// compares every state change (outputs plus dwell time in the previous state).
module tb_multicycle_sequencer;

  logic       clk = 0;
  logic       rst_n, start, halt_req;
  logic       imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, alu_zero;
  logic [7:0] imem_addr, imem_rdata, ir, pc;
  logic [2:0] alu_control, state;
  logic       alu_src, reg_we, mem_to_reg, link_we, busy, fault;

  int asserts = 0;
  int fails   = 0;

  multicycle_sequencer #(.PC_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .alu_zero(alu_zero), .ir(ir), .pc(pc),
    .alu_control(alu_control), .alu_src(alu_src), .reg_we(reg_we),
    .mem_to_reg(mem_to_reg), .link_we(link_we), .state(state),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] I = 0, F = 1, D = 2, E = 3, M = 4, W = 5, H = 6, X = 7;
  // strobes: {imem_req,dmem_req,dmem_we,reg_we,mem_to_reg,link_we,alu_src,busy,fault}
  localparam logic [8:0] K_IDLE = 9'b000000100, K_F    = 9'b100000110,
                         K_G    = 9'b000000110, K_WB   = 9'b000100110,
                         K_MLW  = 9'b010000110, K_WLW  = 9'b000110110,
                         K_WJAL = 9'b000001110, K_SWG  = 9'b000000010,
                         K_MSW  = 9'b011000010, K_HALT = 9'b000000000,
                         K_FH   = 9'b100000010, K_FLT  = 9'b000000001;

  typedef struct { logic [30:0] obs; int dwell; } exp_t;
  typedef struct { logic [7:0] ins; logic az; int dd; } ins_t;
  exp_t sb[$];
  ins_t iq[$];
  exp_t e;
  ins_t cur;

  task automatic ex(input logic [2:0] s, input logic [7:0] p, input logic [7:0] i,
                    input logic [2:0] a, input logic [8:0] k, input int d);
    exp_t t;
    t.obs = {s, p, i, a, k};
    t.dwell = d;
    sb.push_back(t);
  endtask

  task automatic ins(input logic [7:0] v, input logic az, input int dd);
    ins_t t;
    t.ins = v; t.az = az; t.dd = dd;
    iq.push_back(t);
  endtask

  // memory responder: imem acks at once when an instruction is queued,
  // dmem acks after the per-instruction delay
  int ddly = 0, dcnt = 0;
  initial begin
    imem_ack = 0; dmem_ack = 0; imem_rdata = 0; alu_zero = 0;
  end
  always @(negedge clk) begin
    if (imem_req && iq.size() > 0) begin
      cur = iq.pop_front();
      imem_rdata = cur.ins;
      alu_zero   = cur.az;
      ddly       = cur.dd;
      imem_ack   = 1;
    end else begin
      imem_ack = 0;
    end
    if (dmem_req) begin
      if (dcnt == ddly) begin dmem_ack = 1; dcnt = 0; end
      else begin dmem_ack = 0; dcnt++; end
    end else begin
      dmem_ack = 0; dcnt = 0;
    end
  end

  // monitor: on every state change pop one expected record and compare
  logic [2:0]  prev_st;
  logic [30:0] obs;
  int dwell = 0, idx = 0;
  bit seen = 0;
  always @(negedge clk) begin
    obs = {state, pc, ir, alu_control, imem_req, dmem_req, dmem_we, reg_we,
           mem_to_reg, link_we, alu_src, busy, fault};
    if (!seen || state != prev_st) begin
      asserts++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL trace[%0d] unexpected move to state %0d", idx, state);
      end else begin
        e = sb.pop_front();
        if (obs !== e.obs) begin
          fails++;
          $display("FAIL trace[%0d] outputs got %h want %h", idx, obs, e.obs);
        end
        if (e.dwell >= 0) begin
          asserts++;
          if (dwell != e.dwell) begin
            fails++;
            $display("FAIL trace[%0d] dwell got %0d want %0d", idx, dwell, e.dwell);
          end
        end
      end
      idx++;
      dwell   = 1;
      seen    = 1;
      prev_st = state;
    end else begin
      dwell++;
    end
  end

  task automatic wait_st(input logic [2:0] s, input logic [7:0] irv, input string nm);
    bit hit = 0;
    for (int n = 0; n < 300 && !hit; n++) begin
      @(negedge clk);
      if (state == s && ir == irv) hit = 1;
    end
    if (!hit) begin
      asserts++; fails++;
      $display("FAIL %s timeout got state %0d want %0d", nm, state, s);
    end
  endtask

  initial begin
    rst_n = 0; start = 0; halt_req = 0;
    // program: {instr, alu_zero, dmem delay}
    ins(8'h1F, 0, 0); ins(8'hA3, 0, 3); ins(8'h84, 0, 0); ins(8'hCE, 1, 0);
    ins(8'h00, 0, 0); ins(8'hCE, 0, 0); ins(8'h84, 0, 0); ins(8'hD1, 0, 0);
    ins(8'h9A, 0, 0); ins(8'h80, 0, 0); ins(8'hCE, 1, 0); ins(8'h8F, 0, 0);
    ins(8'hB5, 0, 0);
    // expected trace
    ex(I, 8'h00, 8'h00, 0, K_IDLE, -1);
    ex(F, 8'h00, 8'h00, 0, K_F,    -1);
    // add 1F
    ex(D, 8'h01, 8'h1F, 0, K_G,  1); ex(E, 8'h01, 8'h1F, 1, K_G, 1);
    ex(W, 8'h01, 8'h1F, 1, K_WB, 1); ex(F, 8'h01, 8'h1F, 0, K_F, 1);
    // lw A3, dmem ack after 3 extra cycles
    ex(D, 8'h02, 8'hA3, 0, K_G,   1); ex(E, 8'h02, 8'hA3, 2, K_G, 1);
    ex(M, 8'h02, 8'hA3, 2, K_MLW, 1); ex(W, 8'h02, 8'hA3, 2, K_WLW, 4);
    ex(F, 8'h02, 8'hA3, 0, K_F,   1);
    // j 84 -> 04
    ex(D, 8'h03, 8'h84, 0, K_G, 1); ex(E, 8'h03, 8'h84, 0, K_G, 1);
    ex(F, 8'h04, 8'h84, 0, K_F, 1);
    // beq CE taken at 04 -> 03
    ex(D, 8'h05, 8'hCE, 0, K_G, 1); ex(E, 8'h05, 8'hCE, 4, K_G, 1);
    ex(F, 8'h03, 8'hCE, 0, K_F, 1);
    // op 00 at 03
    ex(D, 8'h04, 8'h00, 0, K_G,  1); ex(E, 8'h04, 8'h00, 0, K_G, 1);
    ex(W, 8'h04, 8'h00, 0, K_WB, 1); ex(F, 8'h04, 8'h00, 0, K_F, 1);
    // beq CE not taken -> 05
    ex(D, 8'h05, 8'hCE, 0, K_G, 1); ex(E, 8'h05, 8'hCE, 4, K_G, 1);
    ex(F, 8'h05, 8'hCE, 0, K_F, 1);
    // j 84 -> 04
    ex(D, 8'h06, 8'h84, 0, K_G, 1); ex(E, 8'h06, 8'h84, 0, K_G, 1);
    ex(F, 8'h04, 8'h84, 0, K_F, 1);
    // bne D1 taken at 04 -> 06
    ex(D, 8'h05, 8'hD1, 0, K_G, 1); ex(E, 8'h05, 8'hD1, 5, K_G, 1);
    ex(F, 8'h06, 8'hD1, 0, K_F, 1);
    // jal 9A at 06: link pc 07, then 0A
    ex(D, 8'h07, 8'h9A, 0, K_G,    1); ex(E, 8'h07, 8'h9A, 1, K_G, 1);
    ex(W, 8'h07, 8'h9A, 1, K_WJAL, 1); ex(F, 8'h0A, 8'h9A, 0, K_F, 1);
    // j 80 -> 00
    ex(D, 8'h0B, 8'h80, 0, K_G, 1); ex(E, 8'h0B, 8'h80, 0, K_G, 1);
    ex(F, 8'h00, 8'h80, 0, K_F, 1);
    // beq CE taken at 00 -> wraps to FF
    ex(D, 8'h01, 8'hCE, 0, K_G, 1); ex(E, 8'h01, 8'hCE, 4, K_G, 1);
    ex(F, 8'hFF, 8'hCE, 0, K_F, 1);
    // j 8F at FF: pc wraps to 00 on fetch, then 0F
    ex(D, 8'h00, 8'h8F, 0, K_G, 1); ex(E, 8'h00, 8'h8F, 0, K_G, 1);
    ex(F, 8'h0F, 8'h8F, 0, K_F, 1);
    // sw B5 with halt raised in EXEC: store completes, then HALT
    ex(D, 8'h10, 8'hB5, 0, K_SWG, 1); ex(E, 8'h10, 8'hB5, 3, K_SWG, 1);
    ex(M, 8'h10, 8'hB5, 3, K_MSW, 1); ex(H, 8'h10, 8'hB5, 0, K_HALT, 1);
    // resume; no imem ack ever comes -> FAULT after 15 wait cycles
    ex(F, 8'h10, 8'hB5, 0, K_FH,  -1);
    ex(X, 8'h10, 8'hB5, 0, K_FLT, 15);
    // reset out of FAULT
    ex(I, 8'h00, 8'h00, 0, K_IDLE, -1);

    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;

    wait_st(E, 8'hB5, "sw_exec");
    halt_req = 1;
    wait_st(H, 8'hB5, "halt");
    repeat (3) @(negedge clk);
    halt_req = 0;
    start    = 1;
    @(negedge clk);
    start = 0;

    wait_st(X, 8'hB5, "fault");
    start = 1;  // must be ignored in FAULT
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);

    asserts++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL trace_drain got %0d pending records want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle controller for the 8-bit, 16-opcode datapath.
- Owns the PC and the instruction register (IR), and sequences fetch/decode/execute/memory/writeback.
- Drives the ALU control and register-file/data-memory strobes, one phase at a time.
- Handshakes with instruction and data memory via req/ack, with a watchdog that traps a hung access into a FAULT state.

Parameters:
- PC_W, 8: program counter width in bits; must be at least 4.
- TIMEOUT, 15: maximum cycles to wait for any ack before entering FAULT; the counter is 4 bits wide.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; leaves IDLE and begins fetching at the current PC.
- halt_req  in  1  level; honoured only at an instruction boundary.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address; equals pc.
- imem_rdata  in  8  fetched instruction; valid when imem_ack=1.
- imem_ack  in  1  fetch complete.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load; valid with dmem_req.
- dmem_ack  in  1  data access complete.
- alu_zero  in  1  ALU zero flag, sampled in EXEC.
- ir  out  8  instruction register.
- pc  out  PC_W  program counter.
- alu_control  out  3  equals ir[6:4] during EXEC/MEM/WB, else 0.
- alu_src  out  1  0 only for sw (op 1011), else 1; valid in EXEC.
- reg_we  out  1  one-cycle register-file write strobe in WB.
- mem_to_reg  out  1  1 in WB of lw, else 0.
- link_we  out  1  one-cycle strobe in WB of jal; link value is pc (already pc+1).
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- busy  out  1  high in states 1-5.
- fault  out  1  high in FAULT.

Behaviour:
- **Reset:** asynchronous, while rst_n=0. pc=0, ir=0, state=IDLE, watchdog=0, all strobes/req=0, fault=0, busy=0. Reset mid-access drops req immediately; a late ack after reset is ignored.
- **IDLE:** start=1 moves to FETCH on the next edge.
- **FETCH:**
  - imem_req is held high until imem_ack.
  - On ack: ir<=imem_rdata, pc<=pc+1 (wraps modulo 2^PC_W), go to DECODE.
- **DECODE:** one cycle, no strobes; go to EXEC.
- **EXEC** (one cycle), by op = ir[7:4]:
  - Ops 0000-0111, 1110, 1111 (ALU/imm): go to WB.
  - 1010 lw and 1011 sw: go to MEM.
  - 1000 j: pc<={pc[PC_W-1:4], ir[3:0]}, go to FETCH.
  - 1001 jal: go to WB; the jump is applied at WB.
  - 1100 beq: if alu_zero=1, pc<=pc+sext(ir[3:0]).
  - 1101 bne: if alu_zero=0, pc<=pc+sext(ir[3:0]).
  - beq/bne then go to FETCH. Offsets are relative to the already-incremented pc; arithmetic wraps modulo 2^PC_W.
- **MEM:**
  - dmem_req is held high; dmem_we=1 for sw.
  - On dmem_ack: lw goes to WB, sw goes to FETCH.
- **WB:**
  - reg_we=1 for one cycle (not for jal).
  - jal: link_we=1, then pc<={pc[PC_W-1:4], ir[3:0]} at the end of WB.
  - Then go to FETCH.
- **Instruction boundary:** any transition into FETCH. If halt_req=1 at that point, go to HALT instead.
  - HALT leaves to FETCH when halt_req=0 and start=1.
  - halt_req asserted mid-instruction does not abort; the instruction completes.
- **Watchdog:**
  - Cleared on entry to FETCH/MEM; increments each cycle req is high without ack.
  - When it reaches TIMEOUT with no ack, go to FAULT: req drops, fault=1.
  - FAULT is sticky; only rst_n exits it.
  - An ack in the same cycle the count reaches TIMEOUT wins; no fault.
- **Per-instruction latency** (ack on the first request cycle):
  - ALU/imm: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - j/beq/bne: 3 cycles.
  - jal: 4 cycles.
- **Spurious acks:** acks outside the matching wait state are ignored.

Test Plan:
- Reset then start; imem acks immediately with 0x1F (add) -> states 1,2,3,5,1; reg_we pulses once in WB; alu_control=001; pc=1.
- lw 0xA3 with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0; WB has mem_to_reg=1, reg_we=1; total 8 cycles.
- beq 0xCE at pc=4 with alu_zero=1 -> pc=5-2=3. Same instruction with alu_zero=0 -> pc=5. bne 0xD1 with alu_zero=0 -> pc=6.
- jal 0x97 at pc=0x25 -> link_we pulse with pc=0x26, then pc=0x27. j 0x8F at pc=0xFF -> pc wraps to 0x00 after fetch, then becomes 0x0F.
- imem_ack never arrives, TIMEOUT=15 -> FAULT after 15 wait cycles, imem_req=0, fault=1; start is ignored; rst_n low clears to IDLE.
- halt_req raised during EXEC of sw -> store completes (dmem_we=1), then state=HALT, busy=0. Deassert halt_req and pulse start -> FETCH at the next pc.
